// File: rtl/video_ram_arbiter.sv
// Arbitrates one synchronous single-port video RAM between a strobed video fetcher and a
// level-handshake CPU port. Both use a fixed 3-cycle pipeline: issue, RAM read, output register.
module video_ram_arbiter #(
   parameter int ADDR_W   = 11,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              vidReq,
   input  logic [ADDR_W-1:0] vidAddr,
   output logic [7:0]        vidData,
   output logic              vidValid,
   output logic              vidOverrun,
   input  logic              cpuReq,
   input  logic              cpuWe,
   input  logic [ADDR_W-1:0] cpuAddr,
   input  logic [7:0]        cpuWdata,
   output logic [7:0]        cpuRdata,
   output logic              cpuAck,
   output logic [ADDR_W-1:0] ramAddr,
   output logic              ramWe,
   output logic [7:0]        ramWdata,
   input  logic [7:0]        ramRdata
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE_VID = 2'd1,
      ISSUE_CPU = 2'd2
   } sel_t;

   // Each in-flight stage is tagged with the selector value that issued it;
   // IDLE doubles as the "stage empty" marker.
   sel_t              grant;
   sel_t              s1_sel;
   sel_t              s2_sel;
   logic              s2_we;

   logic              pend_full;
   logic [ADDR_W-1:0] pend_addr;
   logic [3:0]        wait_cnt;

   logic              vid_cand;
   logic              cpu_cand;
   logic              wait_hit;
   logic [ADDR_W-1:0] vid_issue_addr;

   always_comb begin
      vid_cand       = pend_full | vidReq;
      cpu_cand       = cpuReq & (s1_sel != ISSUE_CPU) & (s2_sel != ISSUE_CPU) & ~cpuAck;
      wait_hit       = (wait_cnt == 4'(MAX_WAIT));
      vid_issue_addr = pend_full ? pend_addr : vidAddr;
      grant          = IDLE;
      if (cpu_cand && (!vid_cand || wait_hit)) begin
         grant = ISSUE_CPU;
      end else if (vid_cand) begin
         grant = ISSUE_VID;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_sel     <= IDLE;
         s2_sel     <= IDLE;
         s2_we      <= 1'b0;
         pend_full  <= 1'b0;
         pend_addr  <= '0;
         wait_cnt   <= '0;
         ramAddr    <= '0;
         ramWe      <= 1'b0;
         ramWdata   <= '0;
         vidData    <= '0;
         vidValid   <= 1'b0;
         cpuRdata   <= '0;
         cpuAck     <= 1'b0;
         vidOverrun <= 1'b0;
      end else begin
         s1_sel <= grant;
         s2_sel <= s1_sel;
         s2_we  <= ramWe;

         ramWe <= 1'b0;
         case (grant)
            ISSUE_VID: ramAddr <= vid_issue_addr;
            ISSUE_CPU: begin
               ramAddr  <= cpuAddr;
               ramWe    <= cpuWe;
               ramWdata <= cpuWdata;
            end
            default: ;
         endcase

         if (cpu_cand && grant != ISSUE_CPU) begin
            if (!wait_hit) begin
               wait_cnt <= wait_cnt + 4'd1;
            end
         end else begin
            wait_cnt <= '0;
         end

         // A buffered strobe always goes first; a live strobe in the same cycle takes its place.
         if (grant == ISSUE_VID) begin
            if (pend_full) begin
               pend_full <= vidReq;
               if (vidReq) begin
                  pend_addr <= vidAddr;
               end
            end
         end else if (vidReq) begin
            if (pend_full) begin
               vidOverrun <= 1'b1;
            end else begin
               pend_full <= 1'b1;
               pend_addr <= vidAddr;
            end
         end

         vidValid <= 1'b0;
         cpuAck   <= 1'b0;
         case (s2_sel)
            ISSUE_VID: begin
               vidValid <= 1'b1;
               vidData  <= ramRdata;
            end
            ISSUE_CPU: begin
               cpuAck <= 1'b1;
               if (!s2_we) begin
                  cpuRdata <= ramRdata;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_video_ram_arbiter.sv
// Directed bench for video_ram_arbiter with a read-first synchronous RAM model.
// Each tick lands 1 ns after a rising edge; inputs set there belong to the cycle that follows.
module tb_video_ram_arbiter;

   localparam int ADDR_W = 11;

   logic              clk = 1'b0;
   logic              reset;
   logic              vidReq;
   logic [ADDR_W-1:0] vidAddr;
   logic [7:0]        vidData;
   logic              vidValid;
   logic              vidOverrun;
   logic              cpuReq;
   logic              cpuWe;
   logic [ADDR_W-1:0] cpuAddr;
   logic [7:0]        cpuWdata;
   logic [7:0]        cpuRdata;
   logic              cpuAck;
   logic [ADDR_W-1:0] ramAddr;
   logic              ramWe;
   logic [7:0]        ramWdata;
   logic [7:0]        ramRdata;

   logic [7:0] mem [0:(1<<ADDR_W)-1];

   int total  = 0;
   int passed = 0;
   int fails  = 0;

   video_ram_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .vidReq     (vidReq),
      .vidAddr    (vidAddr),
      .vidData    (vidData),
      .vidValid   (vidValid),
      .vidOverrun (vidOverrun),
      .cpuReq     (cpuReq),
      .cpuWe      (cpuWe),
      .cpuAddr    (cpuAddr),
      .cpuWdata   (cpuWdata),
      .cpuRdata   (cpuRdata),
      .cpuAck     (cpuAck),
      .ramAddr    (ramAddr),
      .ramWe      (ramWe),
      .ramWdata   (ramWdata),
      .ramRdata   (ramRdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ramWe) mem[ramAddr] <= ramWdata;
      ramRdata <= mem[ramAddr];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'h00;
      mem[11'h123] = 8'hA5;
      for (int k = 0; k < 32; k++) mem[11'h100 + k] = 8'h40 + 8'(k);

      reset = 1'b1; vidReq = 1'b0; vidAddr = '0;
      cpuReq = 1'b0; cpuWe = 1'b0; cpuAddr = '0; cpuWdata = '0;
      tick(); tick();
      reset = 1'b0;

      chk("rst_ramAddr", 32'(ramAddr), 32'h0);
      chk("rst_ramWe", 32'(ramWe), 32'h0);
      chk("rst_ramWdata", 32'(ramWdata), 32'h0);
      chk("rst_vidData", 32'(vidData), 32'h0);
      chk("rst_vidValid", 32'(vidValid), 32'h0);
      chk("rst_vidOverrun", 32'(vidOverrun), 32'h0);
      chk("rst_cpuRdata", 32'(cpuRdata), 32'h0);
      chk("rst_cpuAck", 32'(cpuAck), 32'h0);

      // single video read
      vidReq = 1'b1; vidAddr = 11'h123;
      tick(); vidReq = 1'b0;
      chk("vid1_ramAddr", 32'(ramAddr), 32'h123);
      chk("vid1_ramWe", 32'(ramWe), 32'h0);
      tick();
      chk("vid1_early", 32'(vidValid), 32'h0);
      tick();
      chk("vid1_valid", 32'(vidValid), 32'h1);
      chk("vid1_data", 32'(vidData), 32'hA5);
      chk("vid1_noack", 32'(cpuAck), 32'h0);
      tick();
      chk("vid1_pulse", 32'(vidValid), 32'h0);
      chk("vid1_hold", 32'(vidData), 32'hA5);

      // CPU write then read back
      cpuReq = 1'b1; cpuWe = 1'b1; cpuAddr = 11'h7FF; cpuWdata = 8'h3C;
      tick();
      chk("wr_ramWe", 32'(ramWe), 32'h1);
      chk("wr_ramAddr", 32'(ramAddr), 32'h7FF);
      chk("wr_ramWdata", 32'(ramWdata), 32'h3C);
      tick();
      chk("wr_we_once", 32'(ramWe), 32'h0);
      chk("wr_addr_hold", 32'(ramAddr), 32'h7FF);
      chk("wr_early_ack", 32'(cpuAck), 32'h0);
      tick();
      chk("wr_ack", 32'(cpuAck), 32'h1);
      chk("wr_rdata_kept", 32'(cpuRdata), 32'h0);
      cpuReq = 1'b0;
      tick();
      chk("wr_ack_pulse", 32'(cpuAck), 32'h0);
      cpuReq = 1'b1; cpuWe = 1'b0;
      tick();
      chk("rd_ramAddr", 32'(ramAddr), 32'h7FF);
      chk("rd_ramWe", 32'(ramWe), 32'h0);
      tick(); tick();
      chk("rd_ack", 32'(cpuAck), 32'h1);
      chk("rd_data", 32'(cpuRdata), 32'h3C);
      cpuReq = 1'b0;
      tick();

      // CPU write followed by video read of the same address
      cpuReq = 1'b1; cpuWe = 1'b1; cpuAddr = 11'h055; cpuWdata = 8'h99;
      tick();
      vidReq = 1'b1; vidAddr = 11'h055;
      tick(); vidReq = 1'b0;
      chk("ord_vid_addr", 32'(ramAddr), 32'h055);
      tick();
      chk("ord_ack", 32'(cpuAck), 32'h1);
      chk("ord_excl_a", 32'(vidValid), 32'h0);
      cpuReq = 1'b0;
      tick();
      chk("ord_valid", 32'(vidValid), 32'h1);
      chk("ord_data", 32'(vidData), 32'h99);
      chk("ord_excl_b", 32'(cpuAck), 32'h0);
      tick(); tick(); tick();

      // video every cycle; CPU forced in at cycle 4, then a second forced grant overruns
      cpuWe = 1'b0;
      for (int k = 0; k <= 17; k++) begin
         case (k)
            3:  begin chk("st_v0_valid", 32'(vidValid), 32'h1); chk("st_v0_data", 32'(vidData), 32'h40); end
            5:  begin chk("st_cpu_addr", 32'(ramAddr), 32'h7FF); chk("st_cpu_we", 32'(ramWe), 32'h0); end
            6:  chk("st_pend_addr", 32'(ramAddr), 32'h104);
            7:  begin chk("st_ack", 32'(cpuAck), 32'h1); chk("st_rdata", 32'(cpuRdata), 32'h3C);
                      chk("st_excl", 32'(vidValid), 32'h0); end
            8:  begin chk("st_pend_valid", 32'(vidValid), 32'h1); chk("st_pend_data", 32'(vidData), 32'h44); end
            12: begin chk("ov_before", 32'(vidOverrun), 32'h0); chk("ov_pre_addr", 32'(ramAddr), 32'h10A); end
            13: begin chk("ov_set", 32'(vidOverrun), 32'h1); chk("ov_cpu_addr", 32'(ramAddr), 32'h123); end
            14: chk("ov_pend_addr", 32'(ramAddr), 32'h10B);
            15: begin chk("ov_ack", 32'(cpuAck), 32'h1); chk("ov_rdata", 32'(cpuRdata), 32'hA5);
                      chk("ov_next_addr", 32'(ramAddr), 32'h10D); end
            16: begin chk("ov_pend_valid", 32'(vidValid), 32'h1); chk("ov_pend_data", 32'(vidData), 32'h4B); end
            17: begin chk("ov_skip_data", 32'(vidData), 32'h4D); chk("ov_sticky", 32'(vidOverrun), 32'h1); end
            default: ;
         endcase
         vidReq  = (k <= 16);
         vidAddr = 11'h100 + 11'(k);
         if (k <= 6) begin
            cpuReq = 1'b1; cpuAddr = 11'h7FF;
         end else if (k >= 8 && k <= 14) begin
            cpuReq = 1'b1; cpuAddr = 11'h123;
         end else begin
            cpuReq = 1'b0;
         end
         tick();
      end
      vidReq = 1'b0;
      tick(); tick(); tick(); tick();

      // reset in the middle of an in-flight CPU read
      cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 11'h123;
      tick();
      chk("rr_issue", 32'(ramAddr), 32'h123);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rr_ack", 32'(cpuAck), 32'h0);
      chk("rr_cpuRdata", 32'(cpuRdata), 32'h0);
      chk("rr_vidData", 32'(vidData), 32'h0);
      chk("rr_vidValid", 32'(vidValid), 32'h0);
      chk("rr_overrun", 32'(vidOverrun), 32'h0);
      chk("rr_ramAddr", 32'(ramAddr), 32'h0);
      chk("rr_ramWe", 32'(ramWe), 32'h0);
      chk("rr_ramWdata", 32'(ramWdata), 32'h0);
      tick();
      chk("rr_reissue", 32'(ramAddr), 32'h123);
      chk("rr_no_stale", 32'(cpuAck), 32'h0);
      tick(); tick();
      chk("rr_ack2", 32'(cpuAck), 32'h1);
      chk("rr_data2", 32'(cpuRdata), 32'hA5);
      cpuReq = 1'b0;
      tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/video_ram_arbiter.md
VIDEO_RAM_ARBITER -- requirements
Module: video_ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 11, video RAM address width (2 KiB).
REQ-002 Parameter MAX_WAIT, default 4, cycles a pending CPU request may be blocked by video before forced grant (range 1..15).
REQ-003 clk  in  1  single system clock; all state on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 vidReq  in  1  one-cycle strobe, video fetch request.
REQ-006 vidAddr  in  ADDR_W  video fetch address, valid with vidReq.
REQ-007 vidData  out  8  fetched video byte, valid with vidValid.
REQ-008 vidValid  out  1  one-cycle pulse, vidData valid.
REQ-009 vidOverrun  out  1  sticky flag, a video strobe was lost.
REQ-010 cpuReq  in  1  level CPU request, held until cpuAck.
REQ-011 cpuWe  in  1  1 = write, 0 = read; stable while cpuReq.
REQ-012 cpuAddr  in  ADDR_W  CPU address; stable while cpuReq.
REQ-013 cpuWdata  in  8  CPU write data; stable while cpuReq.
REQ-014 cpuRdata  out  8  CPU read data, valid with cpuAck on reads.
REQ-015 cpuAck  out  1  one-cycle pulse, CPU access complete.
REQ-016 ramAddr  out  ADDR_W  registered RAM address.
REQ-017 ramWe  out  1  registered RAM write enable.
REQ-018 ramWdata  out  8  registered RAM write data.
REQ-019 ramRdata  in  8  synchronous single-port RAM read data, valid one cycle after ramAddr.

Function
REQ-020 Pipeline: request decided in cycle N -> ramAddr/ramWe/ramWdata driven in N+1 -> ramRdata in N+2 -> vidData/vidValid or cpuRdata/cpuAck registered, visible in N+3; latency exactly 3 cycles for both requesters and for writes.
REQ-021 Fully pipelined: at most one RAM access issued per cycle, back-to-back issues allowed; when nothing issued, ramWe = 0 and ramAddr holds last value.
REQ-022 Issue selector states: IDLE (no issue), ISSUE_VID, ISSUE_CPU; each in-flight stage carries a valid bit and requester tag.
REQ-023 Video candidate = vidPend buffer if full, else vidReq of current cycle; buffered strobe always served before a new one.
REQ-024 CPU candidate = cpuReq high AND no CPU access in flight (stages N+1..N+3) AND cpuAck not high this cycle.
REQ-025 Priority: video wins over CPU unless waitCnt == MAX_WAIT, then CPU wins.
REQ-026 waitCnt (4 bits): increments each cycle CPU candidate is present and not granted, saturates at MAX_WAIT, clears on CPU grant or when CPU candidate absent.
REQ-027 Forced CPU grant with live vidReq: strobe (address) stored in 1-deep vidPend, issued next cycle.
REQ-028 vidReq arriving while vidPend full and vidPend not issued this cycle: new strobe dropped, vidOverrun set; pending strobe preserved.
REQ-029 vidPend issued and new vidReq same cycle: new strobe refills vidPend (no overrun).
REQ-030 vidOverrun cleared only by reset.
REQ-031 CPU write: ramWe = 1 for exactly the issue cycle; cpuAck at N+3; cpuRdata unchanged on writes.
REQ-032 Ordering: accesses reach RAM in grant order; a CPU write granted before a video read to same address is visible to that read.
REQ-033 vidValid and cpuAck never high in same cycle; vidData/cpuRdata hold value between pulses.

Reset
REQ-034 reset for one edge: all outputs 0 (ramAddr, ramWdata, vidData, cpuRdata 0; ramWe, vidValid, cpuAck, vidOverrun 0), vidPend empty, waitCnt 0, selector IDLE.
REQ-035 Reset mid-operation: all in-flight accesses discarded; no vidValid/cpuAck pulse after reset for pre-reset requests; held cpuReq re-arbitrated from first cycle after reset.

Verification
REQ-036 Single video read: RAM[0x123]=0xA5, vidReq+vidAddr=0x123 at cycle 0 -> ramAddr=0x123 cycle 1, vidValid=1, vidData=0xA5 cycle 3.
REQ-037 CPU write then read: cpuReq write 0x7FF/0x3C -> ramWe=1 cycle 1, cpuAck cycle 3; read 0x7FF next -> cpuAck with cpuRdata=0x3C.
REQ-038 Starvation: vidReq every cycle, cpuReq held -> CPU granted on 5th cycle (MAX_WAIT=4), displaced strobe issued next cycle, vidOverrun remains 0.
REQ-039 Overrun: vidReq every cycle, two CPU requests forced back-to-back with pending full -> vidOverrun=1, pending address still fetched.
REQ-040 Reset at cycle 2 of an in-flight CPU read -> cpuAck stays 0, all outputs 0 after reset, held cpuReq re-issued cycle after reset.
